// File: rtl/hub75_panel_receiver.sv
// hub75_panel_receiver: HUB75 panel model that shifts, latches and times each line and reports it as a record.
module hub75_panel_receiver #(
  parameter int segments = 1,
  parameter int rows = 8,
  parameter int columns = 32,
  parameter int onbits = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [3*segments-1:0]           rgb,
  input  logic                            oclk,
  input  logic                            lat,
  input  logic                            oe,
  input  logic [$clog2(rows)-1:0]         addr,
  output logic                            line_valid,
  output logic [$clog2(rows)-1:0]         line_row,
  output logic [3*segments*columns-1:0]   line_data,
  output logic [onbits-1:0]               line_on_cycles,
  output logic                            shift_error,
  output logic                            overlap_error
);
  localparam int W = 3*segments;
  localparam int AW = $clog2(rows);
  localparam int CW = $clog2(columns+2);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_d;
  logic oclk_q, lat_q, shift_edge, latch_edge;
  logic [W*columns-1:0] sreg, latch;
  logic [AW-1:0] latched_row;
  logic [CW-1:0] shift_cnt;
  logic [onbits-1:0] on_cnt;
  assign shift_edge = oclk & ~oclk_q;
  assign latch_edge = lat & ~lat_q;
  always_comb state_d = (state == IDLE && latch_edge) ? ACTIVE : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oclk_q <= 1'b0;
      lat_q <= 1'b0;
      sreg <= '0;
      latch <= '0;
      latched_row <= '0;
      shift_cnt <= '0;
      on_cnt <= '0;
      line_valid <= 1'b0;
      line_row <= '0;
      line_data <= '0;
      line_on_cycles <= '0;
      shift_error <= 1'b0;
      overlap_error <= 1'b0;
    end else begin
      oclk_q <= oclk;
      lat_q <= lat;
      line_valid <= latch_edge && state == ACTIVE;
      shift_error <= latch_edge && shift_cnt != CW'(columns);
      overlap_error <= oe & lat;
      if (shift_edge) sreg <= {sreg[W*columns-W-1:0], rgb};
      if (latch_edge) begin
        latch <= sreg;
        latched_row <= addr;
        shift_cnt <= CW'(shift_edge);
        on_cnt <= '0;
        if (state == ACTIVE) begin
          line_row <= latched_row;
          line_data <= latch;
          line_on_cycles <= on_cnt;
        end
      end else begin
        if (shift_edge && shift_cnt != CW'(columns+1)) shift_cnt <= shift_cnt + CW'(1);
        // the cycle carrying a latch edge belongs to neither line, so oe is only counted here
        if (state == ACTIVE && oe && !(&on_cnt)) on_cnt <= on_cnt + onbits'(1);
      end
    end
  end
endmodule

// File: tb/tb_hub75_panel_receiver.sv
// tb_hub75_panel_receiver: directed and random stimulus checked against a queue-based panel model.
module tb_hub75_panel_receiver;
  logic clk = 0, rst = 1, oclk = 0, lat = 0, oe = 0;
  logic [2:0] rgb = 0, addr = 0;
  logic line_valid, shift_error, overlap_error;
  logic [2:0] line_row;
  logic [95:0] line_data;
  logic [3:0] line_on_cycles;
  int checks = 0, fails = 0;
  logic [2:0] hist[$];
  int shifts = 0, m_on = 0;
  bit m_active = 0, p_oclk = 0, p_lat = 0;
  logic [2:0] m_row = 0, e_row = 0;
  logic [95:0] m_latch = 0, e_data = 0;
  logic [3:0] e_on = 0;

  hub75_panel_receiver #(.segments(1), .rows(8), .columns(32), .onbits(4)) dut (
    .clk(clk), .rst(rst), .rgb(rgb), .oclk(oclk), .lat(lat), .oe(oe), .addr(addr),
    .line_valid(line_valid), .line_row(line_row), .line_data(line_data),
    .line_on_cycles(line_on_cycles), .shift_error(shift_error), .overlap_error(overlap_error));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // the most recent 32 shifted triples, oldest in column 0 (top slice), zeros where nothing was shifted yet
  function automatic logic [95:0] pack();
    logic [95:0] d = '0;
    int n = hist.size();
    for (int i = 0; i < n; i++) d[95-3*(32-n+i) -: 3] = hist[i];
    return d;
  endfunction

  task automatic model_clear();
    hist.delete();
    shifts = 0; m_on = 0; m_active = 0; p_oclk = 0; p_lat = 0;
    m_row = 0; e_row = 0; m_latch = 0; e_data = 0; e_on = 0;
  endtask

  task automatic cycle(input logic [2:0] r, input logic o, input logic l, input logic e, input logic [2:0] a);
    bit se, le, ev, es, eo;
    rgb = r; oclk = o; lat = l; oe = e; addr = a;
    @(posedge clk); #1;
    se = o && !p_oclk; le = l && !p_lat; p_oclk = o; p_lat = l;
    ev = le && m_active; es = le && shifts != 32; eo = e && l;
    if (ev) begin e_row = m_row; e_data = m_latch; e_on = 4'(m_on); end
    if (le) begin
      m_latch = pack(); m_row = a; m_on = 0; m_active = 1; shifts = int'(se);
    end else begin
      if (m_active && e && m_on < 15) m_on++;
      if (se) shifts++;
    end
    if (se) begin
      hist.push_back(r);
      if (hist.size() > 32) void'(hist.pop_front());
    end
    chk("line_valid", 96'(line_valid), 96'(ev));
    chk("shift_error", 96'(shift_error), 96'(es));
    chk("overlap_error", 96'(overlap_error), 96'(eo));
    chk("line_row", 96'(line_row), 96'(e_row));
    chk("line_data", line_data, e_data);
    chk("line_on_cycles", 96'(line_on_cycles), 96'(e_on));
  endtask

  task automatic shift(input logic [2:0] r);
    cycle(r, 1, 0, 0, 0);
    cycle(r, 0, 0, 0, 0);
  endtask

  task automatic pulse_lat(input logic [2:0] a);
    cycle(0, 0, 1, 0, a);
    cycle(0, 0, 0, 0, a);
  endtask

  task automatic idle(input int n, input logic e);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, e, 0);
  endtask

  task automatic do_reset();
    rst = 1; #1;
    chk("async_reset_valid", 96'(line_valid), 0);
    for (int i = 0; i < 4; i++) begin
      rgb = 3'($urandom); oclk = 1'($urandom); lat = 1'($urandom); oe = 1'($urandom); addr = 3'($urandom);
      @(posedge clk); #1;
      chk("rst_outputs", {line_data, 26'b0, line_valid, shift_error, overlap_error, line_row, line_on_cycles}, 0);
    end
    rgb = 0; oclk = 0; lat = 0; oe = 0; addr = 0;
    @(posedge clk); #1;
    rst = 0;
    model_clear();
  endtask

  initial begin
    do_reset();
    idle(20, 0);
    // first line: column 0 = 101, rest 010; first latch emits nothing
    shift(3'b101);
    for (int i = 1; i < 32; i++) shift(3'b010);
    pulse_lat(3);
    idle(10, 1);
    idle(2, 0);
    pulse_lat(4);
    chk("nominal_row", 96'(line_row), 3);
    chk("nominal_top", 96'(line_data[95:93]), 96'(3'b101));
    chk("nominal_col1", 96'(line_data[92:90]), 96'(3'b010));
    chk("nominal_on", 96'(line_on_cycles), 10);
    // short shift count
    for (int i = 0; i < 31; i++) shift(3'($urandom));
    cycle(0, 0, 1, 0, 5);
    chk("short_serr", 96'(shift_error), 1);
    cycle(0, 0, 0, 0, 5);
    for (int i = 0; i < 32; i++) shift(3'($urandom));
    pulse_lat(6);
    // oclk and lat rising together: the shift belongs to the next line
    for (int i = 0; i < 32; i++) shift(3'($urandom));
    cycle(3'b111, 1, 1, 0, 1);
    chk("simul_serr", 96'(shift_error), 0);
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 31; i++) shift(3'b000);
    cycle(0, 0, 1, 0, 2);
    chk("simul_next_serr", 96'(shift_error), 0);
    cycle(0, 0, 0, 0, 2);
    pulse_lat(2);
    chk("simul_top", 96'(line_data[95:93]), 96'(3'b111));
    // saturation and overlap
    idle(40, 1);
    pulse_lat(7);
    chk("sat_on", 96'(line_on_cycles), 15);
    cycle(0, 0, 1, 1, 0);
    chk("overlap", 96'(overlap_error), 1);
    cycle(0, 0, 0, 0, 0);
    // back-to-back latch edges
    pulse_lat(1);
    chk("b2b_on", 96'(line_on_cycles), 0);
    // reset mid-line
    for (int i = 0; i < 16; i++) shift(3'b111);
    idle(5, 1);
    do_reset();
    for (int i = 0; i < 32; i++) shift(3'b001);
    cycle(0, 0, 1, 0, 3);
    chk("post_rst_valid", 96'(line_valid), 0);
    chk("post_rst_serr", 96'(shift_error), 0);
    cycle(0, 0, 0, 0, 3);
    pulse_lat(4);
    chk("post_rst_data", line_data, {32{3'b001}});
    // random traffic
    for (int i = 0; i < 600; i++)
      cycle(3'($urandom), 1'($urandom), $urandom_range(0, 11) == 0, 1'($urandom), 3'($urandom));
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 32; i++) shift(3'($urandom));
      idle($urandom_range(0, 20), 1);
      pulse_lat(3'($urandom));
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
